// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults (package core) for the unified memory-port arbiter.
// The struct widths track the core's address and data widths.
package core;

    localparam int ADDR_WIDTH   = 32;
    localparam int DATA_WIDTH   = 32;
    localparam int DATA_BYTES   = DATA_WIDTH / 8;
    localparam int STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } mem_arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [DATA_BYTES-1:0] be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_port_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store, MEM first.
// Define MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT back-to-back MEM grants.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = core::DATA_WIDTH,
    parameter int STARVE_LIMIT = core::STARVE_LIMIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,

    input  logic                      if_req_i,
    input  logic [ADDR_WIDTH-1:0]     if_addr_i,
    output logic                      if_gnt_o,
    output logic                      if_rvalid_o,
    output logic [DATA_WIDTH-1:0]     if_rdata_o,

    input  logic                      mem_req_i,
    input  logic                      mem_we_i,
    input  logic [DATA_WIDTH/8-1:0]   mem_be_i,
    input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
    input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
    output logic                      mem_gnt_o,
    output logic                      mem_rvalid_o,
    output logic [DATA_WIDTH-1:0]     mem_rdata_o,

    output logic                      port_req_o,
    output logic                      port_we_o,
    output logic [DATA_WIDTH/8-1:0]   port_be_o,
    output logic [ADDR_WIDTH-1:0]     port_addr_o,
    output logic [DATA_WIDTH-1:0]     port_wdata_o,
    input  logic                      port_ack_i,
    input  logic [DATA_WIDTH-1:0]     port_rdata_i
);

    core::mem_arb_state_e  r_state;
    core::mem_arb_state_e  w_state_next;
    core::mem_port_req_t   r_port;

    logic                  r_drop;
    logic                  r_if_rvalid;
    logic                  r_mem_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_mem_rdata;

    logic                  w_idle;
    logic                  w_starved;
    logic                  w_if_win;
    logic                  w_if_gnt;
    logic                  w_mem_gnt;

    assign w_idle = (r_state == core::IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] r_starve_cnt;

    assign w_starved = (r_starve_cnt >= 4'(STARVE_LIMIT));

    // Saturates so a long flush with MEM traffic cannot wrap the count back below the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (w_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_mem_gnt && if_req_i) begin
            if (r_starve_cnt != 4'hF) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else if (w_idle && !if_req_i) begin
            r_starve_cnt <= '0;
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    assign w_if_win = if_req_i && !flush_i && (!mem_req_i || w_starved);

    // NOTE: every output of a combinational block gets a default first; a missed branch is a latch.
    always_comb begin
        w_state_next = r_state;
        w_if_gnt     = 1'b0;
        w_mem_gnt    = 1'b0;
        unique case (r_state)
            core::IDLE: begin
                // NOTE: grants are gated by rst so every output reads 0 while reset is held.
                w_if_gnt  = w_if_win && rst;
                w_mem_gnt = mem_req_i && !w_if_win && rst;
                if (w_mem_gnt) begin
                    w_state_next = core::BUSY_MEM;
                end else if (w_if_gnt) begin
                    w_state_next = core::BUSY_IF;
                end
            end
            core::BUSY_IF, core::BUSY_MEM: begin
                if (port_ack_i) begin
                    w_state_next = core::IDLE;
                end
            end
            default: w_state_next = core::IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= core::IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Winner's request is captured at the grant edge and held for the whole busy phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_port <= '0;
        end else if (w_mem_gnt) begin
            r_port <= '{we: mem_we_i, be: mem_be_i, addr: mem_addr_i, wdata: mem_wdata_i};
        end else if (w_if_gnt) begin
            r_port <= '{we: 1'b0, be: '1, addr: if_addr_i, wdata: '0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop       <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
        end else begin
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            if (r_state == core::BUSY_IF) begin
                if (port_ack_i) begin
                    // A flush seen at any point of the fetch, ack cycle included, kills delivery.
                    if (!r_drop && !flush_i) begin
                        r_if_rvalid <= 1'b1;
                        r_if_rdata  <= port_rdata_i;
                    end
                    r_drop <= 1'b0;
                end else if (flush_i) begin
                    r_drop <= 1'b1;
                end
            end
            if ((r_state == core::BUSY_MEM) && port_ack_i) begin
                r_mem_rvalid <= 1'b1;
                r_mem_rdata  <= r_port.we ? '0 : port_rdata_i;
            end
        end
    end

    assign if_gnt_o     = w_if_gnt;
    assign mem_gnt_o    = w_mem_gnt;
    assign if_rvalid_o  = r_if_rvalid;
    assign if_rdata_o   = r_if_rdata;
    assign mem_rvalid_o = r_mem_rvalid;
    assign mem_rdata_o  = r_mem_rdata;

    assign port_req_o   = !w_idle;
    assign port_we_o    = r_port.we;
    assign port_be_o    = r_port.be;
    assign port_addr_o  = r_port.addr;
    assign port_wdata_o = r_port.wdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch path (IF) and the load/store path (MEM stage) of the 5-stage core. Holds at most one transaction outstanding on the port and gives MEM priority. An optional starvation guard forces an IF grant after a bounded number of consecutive MEM grants. A low grant to a requester is that stage's stall source.

## Interface
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, core::DATA_WIDTH, data word width; DATA_BYTES = DATA_WIDTH/8.
- STARVE_LIMIT, 4, consecutive MEM grants with IF pending before IF is forced (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  pipeline flush from EX; cancels IF delivery.
- if_req_i  in  1  fetch request; held until if_gnt_o.
- if_addr_i  in  ADDR_WIDTH  fetch address.
- if_gnt_o  out  1  fetch accepted this cycle.
- if_rvalid_o  out  1  one-cycle pulse; if_rdata_o valid.
- if_rdata_o  out  DATA_WIDTH  fetched instruction.
- mem_req_i  in  1  load/store request; held until mem_gnt_o.
- mem_we_i  in  1  1 = store.
- mem_be_i  in  DATA_BYTES  byte enables.
- mem_addr_i  in  ADDR_WIDTH  data address.
- mem_wdata_i  in  DATA_WIDTH  store data.
- mem_gnt_o  out  1  load/store accepted this cycle.
- mem_rvalid_o  out  1  one-cycle completion pulse, loads and stores.
- mem_rdata_o  out  DATA_WIDTH  load data; 0 on stores.
- port_req_o, port_we_o  out  1  port request / write.
- port_be_o  out  DATA_BYTES  port byte enables.
- port_addr_o  out  ADDR_WIDTH  port address.
- port_wdata_o  out  DATA_WIDTH  port write data.
- port_ack_i  in  1  port completes the request this cycle.
- port_rdata_i  in  DATA_WIDTH  read data, valid with port_ack_i.

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY_IF: fetch transaction outstanding.
  - BUSY_MEM: load/store transaction outstanding.
- IDLE arbitration (combinational grant):
  - Only mem_req_i high: mem_gnt_o=1.
  - Only if_req_i high and flush_i low: if_gnt_o=1.
  - Both high: MEM wins, unless the starvation guard is tripped.
  - Never both grants in the same cycle.
  - No request: stay in IDLE.
- On a grant, the winner's request fields are registered into the port registers at the same edge. State moves to BUSY_IF or BUSY_MEM.
- BUSY_*:
  - port_req_o=1; port registers are held stable until port_ack_i.
  - On port_ack_i, port_rdata_i is registered (forced to 0 for stores).
  - At that edge the owner's rvalid is set for exactly one cycle and state returns to IDLE.
- Grants are 0 in BUSY_*; requests are not sampled there.
- Flush:
  - flush_i in IDLE suppresses if_gnt_o that cycle. mem_req_i is still served.
  - flush_i during BUSY_IF, or in the ack cycle of BUSY_IF: the port transaction still completes, but if_rvalid_o stays 0 for that transaction. A sticky drop flag is set, then cleared on return to IDLE.
  - flush_i during BUSY_MEM has no effect.
- Reset (any time, including mid-transaction):
  - State goes to IDLE; all outputs go to 0; counters and flags clear.
  - port_req_o drops immediately. The memory must discard a request dropped by reset.

## Timing
- Grant cycle T. port_req_o is high from T+1.
- Earliest port_ack_i is at T+1, giving rvalid at T+2. That is 2-cycle minimum latency, one transaction per 2 cycles.
- A new grant can be issued in the same cycle rvalid is high, since the state is already IDLE.
- rdata outputs hold their last value until the next rvalid of the same requester.
- port_ack_i is ignored in IDLE.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A 4-bit counter increments on each MEM grant made while if_req_i is high.
  - It clears on an IF grant, and in any IDLE cycle with if_req_i low.
  - When the counter reaches STARVE_LIMIT, the next IDLE cycle with if_req_i high and flush_i low grants IF even if mem_req_i is high.
- Undefined: strict MEM priority; no counter is instantiated.

## Structure
- Package core: the state enum mem_arb_state_e (IDLE, BUSY_IF, BUSY_MEM), the port request struct mem_port_req_t (we, be, addr, wdata), and the default STARVE_LIMIT constant.
- No sub-module. The FSM, port registers and starvation counter live in one module, about 150–250 lines.

## Test plan
- Reset release, if_req_i=1, addr 0x0000_0010; port acks at T+1 with 0x0050_0293 -> if_gnt_o at T, if_rvalid_o at T+2, rdata 0x0050_0293.
- Simultaneous if_req_i/mem_req_i (load 0x100) -> mem_gnt_o first, if_gnt_o at the IDLE cycle after mem_rvalid_o; never both grants high.
- Store be=4'b0011, wdata 0xDEAD_BEEF, ack delayed 3 cycles -> port fields stable for all 4 busy cycles; mem_rvalid_o single pulse, mem_rdata_o=0.
- flush_i during BUSY_IF -> port ack still consumed, if_rvalid_o never pulses; next if_req_i is served normally.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, both requests held high continuously -> 4 MEM grants, then 1 IF grant, repeating. Without the macro, IF is never granted.
- rst asserted in BUSY_MEM -> port_req_o and all outputs 0 asynchronously; after release state is IDLE and no stale rvalid appears.
